// File: rtl/apb_pkg.sv
// Shared types for the APB bridge master: FSM state encoding, error codes and
// the select-index width helper used by the master and its address decoder.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR    = 3'd3,
    RESP   = 3'd4
  } apb_state_e;

  typedef logic [1:0] apb_err_t;

  localparam apb_err_t APB_ERR_NONE = 2'd0;
  localparam apb_err_t APB_ERR_SLV  = 2'd1;
  localparam apb_err_t APB_ERR_DEC  = 2'd2;
  localparam apb_err_t APB_ERR_TMO  = 2'd3;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave-window decoder: equally sized regions starting at
// BASE_ADDR; the top of the window is exclusive.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLV       = 4,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
  parameter int                SLV_SIZE_LOG2 = 12,
  parameter int                IDX_W         = idx_w(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_SLV-1:0] o_sel
);

  // One extra bit so the exclusive upper bound cannot wrap at the top of memory.
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI = LO + ((ADDR_W+1)'(NUM_SLV) << SLV_SIZE_LOG2);

  logic [ADDR_W-1:0] w_off;

  assign o_hit = ({1'b0, i_addr} >= LO) && ({1'b0, i_addr} < HI);
  assign w_off = i_addr - BASE_ADDR;
  assign o_idx = IDX_W'(w_off >> SLV_SIZE_LOG2);

  always_comb begin
    o_sel = '0;
    if (o_hit) o_sel[o_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_master_n.sv
// APB bridge master: valid/ready request in, one-cycle response pulse out,
// with PSTRB, PSLVERR propagation, decode-miss error and ACCESS timeout.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int                NUM_SLV       = 4,
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
  parameter int                SLV_SIZE_LOG2 = 12,
  parameter int                TIMEOUT       = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_w(NUM_SLV);
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e         r_state, w_state_nxt;
  logic               r_req_ready;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_strb;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_SLV-1:0] r_sel;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [DATA_W-1:0]  r_rdata;
  apb_err_t           r_err_code;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_accept;
  logic               w_pready;
  logic               w_pslverr;
  logic [DATA_W-1:0]  w_prdata;
  logic               w_tmo;

  apb_addr_decoder #(
    .NUM_SLV       (NUM_SLV),
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .IDX_W         (IDX_W)
  ) u_dec (
    .i_addr (req_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_sel  (w_sel)
  );

  // Only the latched slave's handshake and data are ever looked at.
  assign w_pready  = PREADY[r_idx];
  assign w_pslverr = PSLVERR[r_idx];
  assign w_prdata  = PRDATA[r_idx*DATA_W +: DATA_W];
  assign w_tmo     = (TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(TIMEOUT));
  assign w_accept  = req_valid && r_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    PSEL        = '0;
    PENABLE     = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE:   if (w_accept) w_state_nxt = w_hit ? SETUP : ERR;
      SETUP:  begin
        PSEL        = r_sel;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = r_sel;
        PENABLE = 1'b1;
        if (w_pready || w_tmo) w_state_nxt = RESP;
      end
      ERR:    w_state_nxt = RESP;
      RESP:   begin
        rsp_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_idx       <= '0;
      r_sel       <= '0;
      r_tmo_cnt   <= '0;
      r_rdata     <= '0;
      r_err_code  <= APB_ERR_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_write ? req_wdata : '0;
        r_strb  <= req_write ? req_strb : '0;
        r_idx   <= w_idx;
        r_sel   <= w_sel;
      end
      if (r_state == SETUP) r_tmo_cnt <= '0;
      else if (r_state == ACCESS && !w_pready) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      // PREADY is checked first so a ready arriving on the timeout cycle still completes.
      case (r_state)
        ACCESS: begin
          if (w_pready) begin
            r_rdata    <= (!r_write && !w_pslverr) ? w_prdata : '0;
            r_err_code <= w_pslverr ? APB_ERR_SLV : APB_ERR_NONE;
          end else if (w_tmo) begin
            r_rdata    <= '0;
            r_err_code <= APB_ERR_TMO;
          end
        end
        ERR: begin
          r_rdata    <= '0;
          r_err_code <= APB_ERR_DEC;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign PADDR     = r_addr;
  assign PWRITE    = r_write;
  assign PWDATA    = r_wdata;
  assign PSTRB     = r_strb;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = (r_err_code != APB_ERR_NONE);

endmodule

// File: tb/tb_apb_master_n.sv
// Self-checking bench for apb_master_n: behavioural slaves with configurable
// wait states / hang / error, and a scoreboard of expected responses.
module tb_apb_master_n;

  localparam int NS = 4;
  localparam int DW = 32;

  logic            PCLK, PRESET;
  logic [31:0]     PADDR;
  logic            PWRITE, PENABLE;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB, PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]   PREADY, PSLVERR;
  logic            req_valid, req_ready, req_write;
  logic [31:0]     req_addr, req_wdata;
  logic [3:0]      req_strb;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  apb_master_n dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave models: s_force makes a slave show PREADY regardless of selection.
  logic [NS-1:0] s_hang, s_err, s_force;
  int            s_wait [NS];
  logic [31:0]   s_rdata [NS];
  int            acc_cnt;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) acc_cnt <= 0;
    else if (PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int i = 0; i < NS; i++) begin
      PREADY[i] = s_force[i] | (PSEL[i] & PENABLE & ~s_hang[i] & (acc_cnt >= s_wait[i]));
      PSLVERR[i] = s_err[i];
      PRDATA[i*DW +: DW] = s_rdata[i];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_errors = 0;

  int          lat, n_access;
  logic [31:0] got_rdata;
  logic        got_err, rsp_next;
  logic [3:0]  psel_log [64];
  logic        pen_log [64];
  logic [3:0]  pstrb_log [64];
  logic [31:0] pwdata_log [64];
  logic [31:0] paddr_log [64];
  logic        pwrite_log [64];

  task automatic slaves_idle();
    s_hang = '0; s_err = '0; s_force = '0;
    for (int i = 0; i < NS; i++) begin
      s_wait[i]  = 0;
      s_rdata[i] = 32'h5A00_0000 | i;
    end
  endtask

  // Drives one request from a negedge, logs bus activity per cycle (cycle 0 =
  // accept), and returns at the negedge following the response cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    int n;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    lat = -1; n_access = 0; got_rdata = 'x; got_err = 1'bx;
    for (int c = 1; c < 100; c++) begin
      @(negedge PCLK);
      if (c < 64) begin
        psel_log[c] = PSEL; pen_log[c] = PENABLE; pstrb_log[c] = PSTRB;
        pwdata_log[c] = PWDATA; paddr_log[c] = PADDR; pwrite_log[c] = PWRITE;
      end
      if (PSEL != 0 && PENABLE) n_access++;
      if (rsp_valid) begin
        lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    @(negedge PCLK);
    rsp_next = rsp_valid;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    slaves_idle();
    #12;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: PSEL=%b PENABLE=%b PADDR=%h rsp_valid=%b expected all 0",
               PSEL, PENABLE, PADDR, rsp_valid);
    end
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL release_req_ready: got %b expected 1", req_ready);
    end
    @(negedge PCLK);
  endtask

  task automatic test_write();
    slaves_idle();
    s_force = 4'b1101; s_err = 4'b1101; s_rdata[1] = 32'hBAD0_BAD0;
    sb.push_back('{32'h0, 1'b0, 3});
    do_req(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 4'b0011);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL wr_rsp: lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
               lat, got_err, got_rdata, e.lat, e.err, e.rdata);
    end
    n_checks++;
    if ({psel_log[1], psel_log[2], psel_log[3]} !== 12'b0010_0010_0000) begin
      n_errors++;
      $display("FAIL wr_psel: got %b %b %b expected 0010 0010 0000", psel_log[1], psel_log[2], psel_log[3]);
    end
    n_checks++;
    if ({pen_log[1], pen_log[2], pen_log[3]} !== 3'b010) begin
      n_errors++;
      $display("FAIL wr_penable: got %b%b%b expected 010", pen_log[1], pen_log[2], pen_log[3]);
    end
    n_checks++;
    if (pstrb_log[1] !== 4'b0011 || pstrb_log[2] !== 4'b0011 || pwdata_log[2] !== 32'hDEAD_BEEF ||
        paddr_log[2] !== 32'h1000_1004 || pwrite_log[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_bus: strb=%b wdata=%h addr=%h write=%b expected 0011 deadbeef 10001004 1",
               pstrb_log[2], pwdata_log[2], paddr_log[2], pwrite_log[2]);
    end
    n_checks++;
    if (paddr_log[3] !== 32'h1000_1004 || rsp_next !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_hold: addr_in_resp=%h rsp_valid_after=%b expected 10001004 0", paddr_log[3], rsp_next);
    end
  endtask

  task automatic test_read_wait();
    logic [3:0]  strb_or;
    logic [31:0] wd_or;
    slaves_idle();
    s_wait[3] = 2; s_rdata[3] = 32'h1234_5678;
    sb.push_back('{32'h1234_5678, 1'b0, 5});
    do_req(1'b0, 32'h1000_3010, 32'hFFFF_FFFF, 4'b1111);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL rd_rsp: lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
               lat, got_err, got_rdata, e.lat, e.err, e.rdata);
    end
    strb_or = '0; wd_or = '0;
    for (int c = 1; c <= 5; c++) begin
      strb_or |= pstrb_log[c]; wd_or |= pwdata_log[c];
    end
    n_checks++;
    if (strb_or !== 4'b0000 || wd_or !== 32'h0 || n_access !== 3) begin
      n_errors++;
      $display("FAIL rd_bus: strb_or=%b wdata_or=%h access=%0d expected 0000 0 3", strb_or, wd_or, n_access);
    end
  endtask

  task automatic test_decode_miss();
    logic [31:0] miss_addr [3];
    logic [3:0]  psel_or;
    miss_addr[0] = 32'h2000_0000; miss_addr[1] = 32'h1000_4000; miss_addr[2] = 32'h0FFF_FFFC;
    slaves_idle();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{32'h0, 1'b1, 2});
      do_req(1'b0, miss_addr[k], 32'h0, 4'h0);
      e = sb.pop_front();
      psel_or = '0;
      for (int c = 1; c <= 2; c++) psel_or |= psel_log[c];
      n_checks++;
      if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata || psel_or !== 4'b0) begin
        n_errors++;
        $display("FAIL miss_%h: lat=%0d err=%b rdata=%h psel=%b expected lat=%0d err=%b rdata=%h psel=0000",
                 miss_addr[k], lat, got_err, got_rdata, psel_or, e.lat, e.err, e.rdata);
      end
    end
    sb.push_back('{32'h7777_0003, 1'b0, 3});
    s_rdata[3] = 32'h7777_0003;
    do_req(1'b0, 32'h1000_3FFC, 32'h0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata || psel_log[2] !== 4'b1000) begin
      n_errors++;
      $display("FAIL top_hit: lat=%0d err=%b rdata=%h psel=%b expected 3 0 77770003 1000",
               lat, got_err, got_rdata, psel_log[2]);
    end
  endtask

  task automatic test_timeout();
    slaves_idle();
    s_hang[2] = 1'b1; s_force = 4'b1011; s_err = 4'b1011;
    sb.push_back('{32'h0, 1'b1, 19});
    do_req(1'b0, 32'h1000_2000, 32'h0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL tmo_rsp: lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
               lat, got_err, got_rdata, e.lat, e.err, e.rdata);
    end
    n_checks++;
    if (n_access !== 17 || psel_log[19] !== 4'b0 || pen_log[19] !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_access: access=%0d psel_resp=%b pen_resp=%b expected 17 0000 0",
               n_access, psel_log[19], pen_log[19]);
    end
    slaves_idle();
    s_rdata[0] = 32'hA5A5_0000;
    sb.push_back('{32'hA5A5_0000, 1'b0, 3});
    do_req(1'b0, 32'h1000_0008, 32'h0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL after_tmo: lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
               lat, got_err, got_rdata, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_ready_at_timeout();
    slaves_idle();
    s_wait[1] = 16; s_rdata[1] = 32'h0BAD_F00D;
    sb.push_back('{32'h0BAD_F00D, 1'b0, 19});
    do_req(1'b0, 32'h1000_1000, 32'h0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata || n_access !== 17) begin
      n_errors++;
      $display("FAIL ready_at_tmo: lat=%0d err=%b rdata=%h access=%0d expected lat=%0d err=%b rdata=%h access=17",
               lat, got_err, got_rdata, n_access, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_pslverr();
    slaves_idle();
    s_err[0] = 1'b1; s_rdata[0] = 32'hFFFF_0000;
    sb.push_back('{32'h0, 1'b1, 3});
    do_req(1'b0, 32'h1000_0000, 32'h0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL pslverr: lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
               lat, got_err, got_rdata, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int          acc_c [2];
    int          rsp_c [2];
    logic [31:0] rsp_d [2];
    logic        rsp_e [2];
    int          na, nr;
    logic        acc_now;
    slaves_idle();
    s_rdata[0] = 32'hCAFE_F00D;
    na = 0; nr = 0;
    acc_c[0] = -100; acc_c[1] = -100; rsp_c[0] = -100; rsp_c[1] = -100;
    rsp_d[0] = 'x; rsp_d[1] = 'x; rsp_e[0] = 1'bx; rsp_e[1] = 1'bx;
    sb.push_back('{32'h0, 1'b0, 3});
    sb.push_back('{32'hCAFE_F00D, 1'b0, 3});
    req_write = 1'b1; req_addr = 32'h1000_2000; req_wdata = 32'h1; req_strb = 4'hF; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid && nr < 2) begin
        rsp_c[nr] = c; rsp_d[nr] = rsp_rdata; rsp_e[nr] = rsp_err; nr++;
      end
      acc_now = req_valid && req_ready;
      if (acc_now && na < 2) begin
        acc_c[na] = c; na++;
      end
      @(posedge PCLK); #1;
      if (acc_now) begin
        if (na == 1) begin
          req_write = 1'b0; req_addr = 32'h1000_0004; req_wdata = '0; req_strb = '0;
        end else req_valid = 1'b0;
      end
      @(negedge PCLK);
    end
    req_valid = 1'b0;
    n_checks++;
    if (acc_c[1] - rsp_c[0] !== 1 || rsp_c[0] - acc_c[0] !== 3) begin
      n_errors++;
      $display("FAIL b2b_timing: acc0=%0d rsp0=%0d acc1=%0d expected rsp0=acc0+3 acc1=rsp0+1",
               acc_c[0], rsp_c[0], acc_c[1]);
    end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_d[k] !== e.rdata || rsp_e[k] !== e.err || rsp_c[k] - acc_c[k] !== e.lat) begin
        n_errors++;
        $display("FAIL b2b_rsp%0d: rdata=%h err=%b lat=%0d expected %h %b %0d",
                 k, rsp_d[k], rsp_e[k], rsp_c[k] - acc_c[k], e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    logic seen_rsp;
    slaves_idle();
    s_hang[2] = 1'b1;
    req_write = 1'b0; req_addr = 32'h1000_2000; req_valid = 1'b1;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    n = 0;
    while (!PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    @(posedge PCLK);
    #3 PRESET = 1'b1;
    #1;
    n_checks++;
    if (PSEL !== 4'b0 || PENABLE !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: PSEL=%b PENABLE=%b req_ready=%b rsp_valid=%b expected 0000 0 0 0",
               PSEL, PENABLE, req_ready, rsp_valid);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    s_hang = '0;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL mid_reset_ready: got %b expected 1", req_ready);
    end
    seen_rsp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      seen_rsp |= rsp_valid;
    end
    n_checks++;
    if (seen_rsp !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_no_rsp: rsp_valid seen=%b expected 0", seen_rsp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_ready_at_timeout();
    test_pslverr();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
